// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer: buffers operand pairs, drives the GCD core bus (start, A, B),
// collects each result (or a zero-operand/timeout error) and returns them in order.
module gcd_job_sequencer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    output logic                       gcd_start,
    output logic [WIDTH-1:0]           gcd_data,
    input  logic                       gcd_done,
    input  logic [WIDTH-1:0]           gcd_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_gcd,
    output logic                       out_err,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT+1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_A,
        S_SEND_B,
        S_WAIT,
        S_OUT
    } state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     fifo_a [DEPTH];
    logic [WIDTH-1:0]     fifo_b [DEPTH];
    logic [PTR_W-1:0]     rd_ptr, wr_ptr;
    logic [CNT_W-1:0]     count_nxt;
    logic [TMR_W-1:0]     timer, timer_nxt;
    logic                 push, pop;
    logic [WIDTH-1:0]     head_a, head_b;
    logic                 start_nxt, valid_nxt, err_nxt;
    logic [WIDTH-1:0]     data_nxt, gcd_nxt;

    assign push      = in_valid && in_ready;
    assign head_a    = fifo_a[rd_ptr];
    assign head_b    = fifo_b[rd_ptr];
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

    // Operand storage; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr] <= in_a;
            fifo_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            gcd_start <= 1'b0;
            gcd_data  <= '0;
            out_valid <= 1'b0;
            out_gcd   <= '0;
            out_err   <= 1'b0;
            timer     <= '0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            // in_ready follows occupancy only; a pop never frees a slot in the same cycle.
            in_ready  <= (count_nxt != CNT_W'(DEPTH));
            busy      <= (state_nxt != S_IDLE) || (count_nxt != '0);
            gcd_start <= start_nxt;
            gcd_data  <= data_nxt;
            out_valid <= valid_nxt;
            out_gcd   <= gcd_nxt;
            out_err   <= err_nxt;
            timer     <= timer_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        start_nxt = gcd_start;
        data_nxt  = gcd_data;
        valid_nxt = out_valid;
        gcd_nxt   = out_gcd;
        err_nxt   = out_err;
        timer_nxt = timer;
        pop       = 1'b0;

        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    // A zero operand is answered locally without touching the core.
                    if ((head_a == '0) || (head_b == '0)) begin
                        pop       = 1'b1;
                        gcd_nxt   = head_a | head_b;
                        err_nxt   = (head_a == '0) && (head_b == '0);
                        state_nxt = S_OUT;
                    end else begin
                        start_nxt = 1'b1;
                        data_nxt  = head_a;
                        state_nxt = S_SEND_A;
                    end
                end
            end
            S_SEND_A: begin
                start_nxt = 1'b1;
                data_nxt  = head_b;
                state_nxt = S_SEND_B;
            end
            S_SEND_B: begin
                start_nxt = 1'b0;
                pop       = 1'b1;
                timer_nxt = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (gcd_done) begin
                    gcd_nxt   = gcd_result;
                    err_nxt   = 1'b0;
                    state_nxt = S_OUT;
                end else if (timer == TMR_W'(TIMEOUT)) begin
                    gcd_nxt   = '0;
                    err_nxt   = 1'b1;
                    state_nxt = S_OUT;
                end else if (timer != '1) begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            S_OUT: begin
                // Result fields stay frozen here until the consumer takes them.
                if (!out_valid) begin
                    valid_nxt = 1'b1;
                end else if (out_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Bench for gcd_job_sequencer: GCD core model, result scoreboard and directed scenarios.
module tb_gcd_job_sequencer;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned CNT_W   = $clog2(DEPTH+1);

    logic             clk, rst, in_valid, in_ready, gcd_start, gcd_done;
    logic             out_valid, out_ready, out_err, busy;
    logic [WIDTH-1:0] in_a, in_b, gcd_data, gcd_result, out_gcd;
    logic [CNT_W-1:0] count;

    typedef struct { logic [WIDTH-1:0] g; logic e; } res_t;
    typedef struct { logic [WIDTH-1:0] a; logic [WIDTH-1:0] b; } pair_t;

    res_t  exp_q[$];
    res_t  got_q[$];
    pair_t core_q[$];
    res_t  mon_r;
    pair_t mon_p;

    int checks = 0;
    int failures = 0;
    int start_cycles = 0;
    bit bus_phase = 1'b0;
    logic [WIDTH-1:0] seen_a = '0, seen_b = '0;

    bit core_stuck = 1'b0;
    bit spur_req = 1'b0;
    int core_lat = 3;
    bit cm_phase = 1'b0, cm_busy = 1'b0;
    int cm_wait = 0;
    logic [WIDTH-1:0] cm_a = '0, cm_b = '0;

    gcd_job_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .gcd_start(gcd_start), .gcd_data(gcd_data), .gcd_done(gcd_done), .gcd_result(gcd_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd), .out_err(out_err),
        .busy(busy), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ref_gcd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x, y, t;
        x = a;
        y = b;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (!in_ready && g < 200) begin
            tick();
            g++;
        end
        if (g >= 200) chk("push_accept", 32'd0, 32'd1);
        else tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int g;
        g = 0;
        while (got_q.size() < n && g < 600) begin
            tick();
            g++;
        end
        chk("result_count", 32'(got_q.size()), 32'(n));
    endtask

    task automatic chk_res(input string name, input int idx, input logic [WIDTH-1:0] g, input logic e);
        if (got_q.size() <= idx) begin
            chk({name, "_missing"}, 32'(got_q.size()), 32'(idx + 1));
        end else begin
            chk({name, "_gcd"}, 32'(got_q[idx].g), 32'(g));
            chk({name, "_err"}, 32'(got_q[idx].e), 32'(e));
        end
    endtask

    // Scoreboard: expected results and core-bus operands derived from each accepted pair.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            core_q.delete();
            bus_phase = 1'b0;
        end else begin
            chk("in_ready_vs_count", 32'(in_ready), 32'(count != CNT_W'(DEPTH)));
            if (count > CNT_W'(DEPTH)) chk("count_range", 32'(count), 32'(DEPTH));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    chk("out_gcd", 32'(out_gcd), 32'(exp_q[0].g));
                    chk("out_err", 32'(out_err), 32'(exp_q[0].e));
                    if (out_ready) begin
                        mon_r.g = out_gcd;
                        mon_r.e = out_err;
                        got_q.push_back(mon_r);
                        exp_q.delete(0);
                    end
                end
            end
            if (gcd_start) begin
                start_cycles++;
                if (core_q.size() == 0) begin
                    chk("unexpected_start", 32'd1, 32'd0);
                end else if (!bus_phase) begin
                    chk("bus_a", 32'(gcd_data), 32'(core_q[0].a));
                    seen_a = gcd_data;
                    bus_phase = 1'b1;
                end else begin
                    chk("bus_b", 32'(gcd_data), 32'(core_q[0].b));
                    seen_b = gcd_data;
                    core_q.delete(0);
                    bus_phase = 1'b0;
                end
            end else if (bus_phase) begin
                chk("start_two_cycles", 32'd0, 32'd1);
                bus_phase = 1'b0;
            end
            if (in_valid && in_ready) begin
                if (in_a == '0 && in_b == '0) begin
                    mon_r.g = '0;
                    mon_r.e = 1'b1;
                end else if (in_a == '0 || in_b == '0) begin
                    mon_r.g = in_a | in_b;
                    mon_r.e = 1'b0;
                end else begin
                    mon_p.a = in_a;
                    mon_p.b = in_b;
                    core_q.push_back(mon_p);
                    mon_r.g = core_stuck ? '0 : ref_gcd(in_a, in_b);
                    mon_r.e = core_stuck;
                end
                exp_q.push_back(mon_r);
            end
        end
    end

    // GCD core model: latches A then B from the bus, answers core_lat cycles later.
    initial begin
        gcd_done = 1'b0;
        gcd_result = 16'hBEEF;
        forever begin
            @(negedge clk);
            gcd_done = 1'b0;
            gcd_result = 16'hBEEF;
            if (rst) begin
                cm_phase = 1'b0;
                cm_busy = 1'b0;
            end else begin
                if (spur_req) begin
                    gcd_done = 1'b1;
                    gcd_result = 16'hDEAD;
                    spur_req = 1'b0;
                end
                if (gcd_start) begin
                    cm_busy = 1'b0;
                    if (!cm_phase) begin
                        cm_a = gcd_data;
                        cm_phase = 1'b1;
                    end else begin
                        cm_b = gcd_data;
                        cm_phase = 1'b0;
                        cm_busy = !core_stuck;
                        cm_wait = core_lat;
                    end
                end else if (cm_busy) begin
                    cm_wait--;
                    if (cm_wait <= 0) begin
                        gcd_done = 1'b1;
                        gcd_result = ref_gcd(cm_a, cm_b);
                        cm_busy = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int s0, k, n0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;
        ticks(3);
        rst = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_gcd_start", 32'(gcd_start), 32'd0);
        chk("rst_gcd_data", 32'(gcd_data), 32'd0);
        chk("rst_out_gcd", 32'(out_gcd), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Single job through the core.
        out_ready = 1'b1;
        s0 = start_cycles;
        push(16'd26, 16'd39);
        wait_results(1);
        chk_res("t1", 0, 16'd13, 1'b0);
        chk("t1_start_cycles", 32'(start_cycles - s0), 32'd2);
        chk("t1_bus_a", 32'(seen_a), 32'd26);
        chk("t1_bus_b", 32'(seen_b), 32'd39);

        // Back-pressure: FIFO fills while the first result is held.
        out_ready = 1'b0;
        push(16'd12, 16'd18);
        push(16'd7, 16'd5);
        push(16'd9, 16'd9);
        push(16'd100, 16'd75);
        push(16'd1071, 16'd462);
        ticks(12);
        chk("t2_count_full", 32'(count), 32'd4);
        chk("t2_in_ready_low", 32'(in_ready), 32'd0);
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        chk("t2_held_gcd", 32'(out_gcd), 32'd6);
        chk("t2_busy", 32'(busy), 32'd1);
        out_ready = 1'b1;
        wait_results(6);
        chk_res("t2_r0", 1, 16'd6, 1'b0);
        chk_res("t2_r1", 2, 16'd1, 1'b0);
        chk_res("t2_r2", 3, 16'd9, 1'b0);
        chk_res("t2_r3", 4, 16'd25, 1'b0);
        chk_res("t2_r4", 5, 16'd21, 1'b0);

        // Zero-operand bypass jobs.
        s0 = start_cycles;
        push(16'd0, 16'd7);
        push(16'd0, 16'd0);
        push(16'd48, 16'd0);
        wait_results(9);
        chk_res("t3_0_7", 6, 16'd7, 1'b0);
        chk_res("t3_0_0", 7, 16'd0, 1'b1);
        chk_res("t3_48_0", 8, 16'd48, 1'b0);
        chk("t3_no_start", 32'(start_cycles - s0), 32'd0);

        // Timeout with done stuck low.
        core_stuck = 1'b1;
        push(16'd21, 16'd14);
        k = 0;
        while (!gcd_start && k < 20) begin tick(); k++; end
        k = 0;
        while (gcd_start && k < 20) begin tick(); k++; end
        k = 0;
        while (!out_err && k < 40) begin tick(); k++; end
        chk("t4_timeout_latency", 32'(k), 32'd16);
        chk("t4_timeout_gcd", 32'(out_gcd), 32'd0);
        wait_results(10);
        chk_res("t4_timeout", 9, 16'd0, 1'b1);
        core_stuck = 1'b0;
        push(16'd21, 16'd14);
        wait_results(11);
        chk_res("t4_next", 10, 16'd7, 1'b0);

        // Reset while a job is in WAIT with two pairs queued.
        core_lat = 10;
        push(16'd26, 16'd39);
        push(16'd12, 16'd18);
        push(16'd7, 16'd5);
        ticks(4);
        chk("t5_pre_count", 32'(count), 32'd2);
        chk("t5_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_gcd_start", 32'(gcd_start), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        core_lat = 3;
        push(16'd26, 16'd39);
        wait_results(12);
        chk_res("t5_fresh", 11, 16'd13, 1'b0);

        // Stray done pulses in IDLE and OUT.
        ticks(3);
        n0 = got_q.size();
        spur_req = 1'b1;
        ticks(3);
        chk("t6_idle_valid", 32'(out_valid), 32'd0);
        chk("t6_idle_busy", 32'(busy), 32'd0);
        chk("t6_idle_results", 32'(got_q.size()), 32'(n0));
        out_ready = 1'b0;
        push(16'd0, 16'd5);
        ticks(4);
        chk("t6_out_valid_pre", 32'(out_valid), 32'd1);
        spur_req = 1'b1;
        ticks(3);
        chk("t6_out_valid_post", 32'(out_valid), 32'd1);
        chk("t6_out_gcd_post", 32'(out_gcd), 32'd5);
        chk("t6_out_err_post", 32'(out_err), 32'd0);
        out_ready = 1'b1;
        wait_results(13);
        chk_res("t6_held", 12, 16'd5, 1'b0);
        push(16'd1071, 16'd462);
        wait_results(14);
        chk_res("t6_after", 13, 16'd21, 1'b0);

        ticks(5);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_exp_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
